// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the I2S and HDMI audio paths.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SAMPLE_W = 16;

  // NCO increment for an I2S bit clock (two ticks per BCLK period, 2*slot BCLKs per frame).
  // Returns 0 when the rate is too high for ticks to stay at least one cycle apart.
  function automatic int i2s_inc(input int clk_hz, input int fs, input int slot);
    int inc;
    inc = 4 * fs * slot;
    if (2 * inc > clk_hz) inc = 0;
    return inc;
  endfunction

endpackage

// File: rtl/audio_nco.sv
// Fractional NCO: emits exactly INC single-cycle ticks every CLK_HZ cycles.
module audio_nco #(
  parameter int CLK_HZ = 32000000,
  parameter int INC    = 3072000
) (
  input  logic clk32,
  input  logic por,
  output logic tick
);

  localparam int AW = $clog2(CLK_HZ + INC);
  localparam logic [AW-1:0] INC_W = AW'(INC);
  localparam logic [AW-1:0] CLK_W = AW'(CLK_HZ);

  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_sum;
  logic          w_tick;

  assign w_sum  = r_acc + INC_W;
  assign w_tick = (w_sum >= CLK_W);
  assign tick   = w_tick;

  // Phase accumulator; wraps modulo CLK_HZ and flags the wrap as a tick.
  always_ff @(posedge clk32) begin
    if (por)         r_acc <= '0;
    else if (w_tick) r_acc <= w_sum - CLK_W;
    else             r_acc <= w_sum;
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: NCO-paced BCLK, MSB-first data with one BCLK delay after LRCK.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 32000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int SLOT_BITS = 16
) (
  input  logic    clk32,
  input  logic    por,
  input  sample_t audio_l,
  input  sample_t audio_r,
  input  logic    mute,
  output logic    sample_req,
  output logic    i2s_bclk,
  output logic    i2s_lrck,
  output logic    i2s_din
);

  localparam int INC = i2s_inc(CLK_HZ, SAMPLE_HZ, SLOT_BITS);
  localparam int FW  = 2 * SLOT_BITS;
  localparam int CW  = $clog2(FW);
  localparam logic [CW-1:0] LAST   = CW'(FW - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);

  if (INC == 0 || SLOT_BITS < 16 || SLOT_BITS > 32) begin : g_bad_params
    $error("i2s_tx: illegal CLK_HZ/SAMPLE_HZ/SLOT_BITS combination");
  end

  logic            w_tick;
  logic            w_fall;
  logic            w_wrap;
  logic [CW-1:0]   w_cnt_next;
  logic [SLOT_BITS-1:0] w_slot_l;
  logic [SLOT_BITS-1:0] w_slot_r;
  logic [FW-1:0]   w_frame;

  logic            r_bclk;
  logic            r_lrck;
  logic            r_din;
  logic [CW-1:0]   r_bit_cnt;
  logic [FW-1:0]   r_sr;

  audio_nco #(.CLK_HZ(CLK_HZ), .INC(INC)) u_nco (
    .clk32 (clk32),
    .por   (por),
    .tick  (w_tick)
  );

  // Samples sit MSB-aligned in their slots; the tail of each slot is zero pad.
  assign w_slot_l = SLOT_BITS'($unsigned(audio_l)) << (SLOT_BITS - SAMPLE_W);
  assign w_slot_r = SLOT_BITS'($unsigned(audio_r)) << (SLOT_BITS - SAMPLE_W);
  assign w_frame  = mute ? '0 : {w_slot_l, w_slot_r};

  assign w_fall     = w_tick & r_bclk;
  assign w_wrap     = w_fall & (r_bit_cnt == LAST);
  assign w_cnt_next = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + CW'(1);

  // Capture happens on the coming edge, so the request is asserted in that same cycle.
  assign sample_req = w_wrap & ~por;

  // BCLK toggle; data, word select and bit counter advance only on falling ticks.
  always_ff @(posedge clk32) begin
    if (por) begin
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_din     <= 1'b0;
      r_bit_cnt <= '0;
      r_sr      <= '0;
    end else if (w_tick) begin
      r_bclk <= ~r_bclk;
      if (r_bclk) begin
        r_bit_cnt <= w_cnt_next;
        r_lrck    <= (w_cnt_next >= SLOT_C);
        r_din     <= r_sr[FW-1];
        r_sr      <= w_wrap ? w_frame : (r_sr << 1);
      end
    end
  end

  assign i2s_bclk = r_bclk;
  assign i2s_lrck = r_lrck;
  assign i2s_din  = r_din;

endmodule
